e203_ifu_flush_rsp: RTL and testbench
=====================================

Name: e203_ifu_flush_rsp

Overview:
- IFU-side responder for the EXU commit flush interface.
- Accepts `pipe_flush_req` with adder operands, computes the redirect PC and acknowledges the flush.
- Issues a one-cycle PC redirect to the fetch address generator.
- Tracks outstanding instruction-fetch bus transactions, so responses belonging to pre-flush fetches are marked for drop and never reach the IR stage.

Parameters:
- PC_SIZE, 32, width of PC and flush adder operands.
- OUTS_W, 2, width of outstanding/drop counters.
- MAX_OUTS, 2, maximum in-flight fetch requests (must be ≤ 2^OUTS_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_flush_req  in  1  flush request from commit
- pipe_flush_add_op1  in  PC_SIZE  redirect adder operand 1
- pipe_flush_add_op2  in  PC_SIZE  redirect adder operand 2
- pipe_flush_ack  out  1  flush accepted this cycle
- ifu_req_hsked  in  1  fetch request handshake completed on bus
- ifu_rsp_hsked  in  1  fetch response handshake completed on bus
- ifu_rsp_drop  out  1  current response is stale; discard
- fetch_allow  out  1  fetch generator may issue a new request this cycle
- pc_redir_vld  out  1  one-cycle redirect strobe
- pc_redir  out  PC_SIZE  redirect target, valid with pc_redir_vld
- outs_cnt  out  OUTS_W  current outstanding fetch count (debug/perf)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, outs_cnt=0, drop_cnt=0, pc_redir=0, pc_redir_vld=0.
- pipe_flush_ack and ifu_rsp_drop are combinational; each is 0 while rst=1.
- States:
  - IDLE: normal operation.
  - REDIR: one cycle, drives the redirect.
- flush_accept = (state==IDLE) & pipe_flush_req. pipe_flush_ack = flush_accept.
- No ack in REDIR: a req presented in REDIR is held by commit and acked on the following IDLE cycle.
- On flush_accept:
  - latch pc_redir = (op1+op2) mod 2^PC_SIZE with bit0 forced 0;
  - next state=REDIR.
- REDIR: pc_redir_vld=1 for exactly one cycle; next state=IDLE unconditionally.
- Latency: ack in cycle N → pc_redir_vld in cycle N+1.
- outs_cnt_nxt = outs_cnt + ifu_req_hsked − ifu_rsp_hsked.
  - Never underflows: a rsp with outs_cnt=0 and no req that cycle leaves the count at 0.
  - Never exceeds MAX_OUTS.
- fetch_allow = (state==IDLE) & ~pipe_flush_req & (outs_cnt < MAX_OUTS).
  - ifu_req_hsked asserted while fetch_allow=0 is a protocol violation; still counted, saturated at MAX_OUTS.
- ifu_rsp_drop = ifu_rsp_hsked & ((drop_cnt != 0) | flush_accept).
  - A response in the same cycle as the ack belongs to an older fetch and is dropped.
- drop_cnt update, priority order:
  1. flush_accept: drop_cnt = outs_cnt_nxt. Includes a req handshaking in the ack cycle and excludes a rsp completing in it.
  2. else ifu_rsp_hsked & drop_cnt != 0: drop_cnt − 1.
  3. else hold.
- Back-to-back flush while drop_cnt != 0: the second ack overwrites drop_cnt with outs_cnt_nxt. Nothing is double-counted, since all in-flight fetches are already stale.
- Reset mid-REDIR: the pending redirect is discarded; no pc_redir_vld pulse after reset.
- pc_redir holds its last value outside REDIR.

Test Plan:
- Idle flush: outs_cnt=0, req with op1=0x8000_0000, op2=0x0000_0104 → ack cycle N; pc_redir_vld=1, pc_redir=0x8000_0104 in N+1 only; drop_cnt=0.
- Odd sum: op1=0x0000_1001, op2=0x0000_0002 → pc_redir=0x0000_1002; overflow op1=0xFFFF_FFFE, op2=0x4 → pc_redir=0x0000_0002.
- Drain drop: issue 2 reqs (outs_cnt=2), flush acked → drop_cnt=2; next 2 rsps have ifu_rsp_drop=1; third rsp (post-redirect fetch) has ifu_rsp_drop=0; outs_cnt returns to 0.
- Same-cycle events: outs_cnt=1, flush_accept with ifu_req_hsked=1 and ifu_rsp_hsked=1 → that rsp dropped, drop_cnt=1; next rsp dropped; following rsp kept.
- Flush held in REDIR: req held high for 3 cycles → acks in cycles N and N+2, pc_redir_vld in N+1 and N+3; fetch_allow=0 throughout.
- Reset in REDIR: rst=1 in cycle N+1 after ack → pc_redir_vld=0, outs_cnt=0, drop_cnt=0, state IDLE in N+2.

Source files
------------

// File: rtl/e203_ifu_flush_rsp.sv
// IFU flush responder: acknowledges commit flushes, issues a one-cycle PC redirect,
// and marks fetch responses that belong to pre-flush requests for drop.
module e203_ifu_flush_rsp #(
  parameter int PC_SIZE  = 32,
  parameter int OUTS_W   = 2,
  parameter int MAX_OUTS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_ack,
  input  logic               ifu_req_hsked,
  input  logic               ifu_rsp_hsked,
  output logic               ifu_rsp_drop,
  output logic               fetch_allow,
  output logic               pc_redir_vld,
  output logic [PC_SIZE-1:0] pc_redir,
  output logic [OUTS_W-1:0]  outs_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  localparam logic [OUTS_W-1:0] MAX_CNT = OUTS_W'(MAX_OUTS);
  localparam logic [OUTS_W-1:0] CNT_ONE = OUTS_W'(1);

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [OUTS_W-1:0]  outs_cnt_r;
  logic [OUTS_W-1:0]  outs_cnt_nxt;
  logic [OUTS_W-1:0]  drop_cnt;
  logic [OUTS_W-1:0]  drop_cnt_nxt;
  logic [PC_SIZE-1:0] pc_sum;
  logic               flush_accept;
  logic               drop_pending;

  // Combinational outputs are gated by rst so nothing leaks out during reset.
  assign flush_accept   = ~rst & (state == ST_IDLE) & pipe_flush_req;
  assign pipe_flush_ack = flush_accept;
  assign drop_pending   = (drop_cnt != '0);
  assign ifu_rsp_drop   = ~rst & ifu_rsp_hsked & (drop_pending | flush_accept);

  assign fetch_allow  = (state == ST_IDLE) & ~pipe_flush_req & (outs_cnt_r < MAX_CNT);
  assign pc_redir_vld = (state == ST_REDIR);
  assign outs_cnt     = outs_cnt_r;

  assign pc_sum = pipe_flush_add_op1 + pipe_flush_add_op2;

  // Outstanding count: saturates at MAX_OUTS on protocol-violating requests
  // and never underflows on a spurious response.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    outs_cnt_nxt = outs_cnt_r;
    if (ifu_req_hsked && !ifu_rsp_hsked) begin
      if (outs_cnt_r < MAX_CNT) outs_cnt_nxt = outs_cnt_r + CNT_ONE;
    end else if (!ifu_req_hsked && ifu_rsp_hsked) begin
      if (outs_cnt_r != '0) outs_cnt_nxt = outs_cnt_r - CNT_ONE;
    end
  end

  // A new flush makes every fetch still in flight after this cycle stale;
  // a response retiring in the ack cycle is already dropped directly.
  always_comb begin
    drop_cnt_nxt = drop_cnt;
    if (flush_accept) begin
      drop_cnt_nxt = outs_cnt_nxt;
    end else if (ifu_rsp_hsked && drop_pending) begin
      drop_cnt_nxt = drop_cnt - CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (flush_accept) state_nxt = ST_REDIR;
      ST_REDIR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      outs_cnt_r <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      outs_cnt_r <= outs_cnt_nxt;
      drop_cnt   <= drop_cnt_nxt;
    end
  end

  // Redirect target is halfword aligned; it holds between flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_redir <= '0;
    end else if (flush_accept) begin
      pc_redir <= {pc_sum[PC_SIZE-1:1], 1'b0};
    end
  end

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Directed self-checking bench for e203_ifu_flush_rsp: redirect math, latency,
// drop accounting, held flush, reset mid-redirect and counter saturation.
module tb_e203_ifu_flush_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_add_op1;
  logic [31:0] pipe_flush_add_op2;
  logic        pipe_flush_ack;
  logic        ifu_req_hsked;
  logic        ifu_rsp_hsked;
  logic        ifu_rsp_drop;
  logic        fetch_allow;
  logic        pc_redir_vld;
  logic [31:0] pc_redir;
  logic [1:0]  outs_cnt;

  int total = 0;
  int bad   = 0;

  e203_ifu_flush_rsp #(.PC_SIZE(32), .OUTS_W(2), .MAX_OUTS(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .pipe_flush_req     (pipe_flush_req),
    .pipe_flush_add_op1 (pipe_flush_add_op1),
    .pipe_flush_add_op2 (pipe_flush_add_op2),
    .pipe_flush_ack     (pipe_flush_ack),
    .ifu_req_hsked      (ifu_req_hsked),
    .ifu_rsp_hsked      (ifu_rsp_hsked),
    .ifu_rsp_drop       (ifu_rsp_drop),
    .fetch_allow        (fetch_allow),
    .pc_redir_vld       (pc_redir_vld),
    .pc_redir           (pc_redir),
    .outs_cnt           (outs_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge and checks
  // are made 3 units later, well clear of both clock edges.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic req, input logic [31:0] op1, input logic [31:0] op2,
                       input logic rq, input logic rs);
    pipe_flush_req     = req;
    pipe_flush_add_op1 = op1;
    pipe_flush_add_op2 = op2;
    ifu_req_hsked      = rq;
    ifu_rsp_hsked      = rs;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    settle();
    check("ack_in_rst", pipe_flush_ack, 0);
    check("drop_in_rst", ifu_rsp_drop, 0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    settle();
    check("rst_outs", outs_cnt, 0);
    check("rst_vld", pc_redir_vld, 0);
    check("rst_pc", pc_redir, 0);

    // Idle flush
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'h0000_0104, 1'b0, 1'b0);
    settle();
    check("idle_ack", pipe_flush_ack, 1);
    check("idle_fa_req", fetch_allow, 0);
    check("idle_vld_n", pc_redir_vld, 0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("idle_vld_n1", pc_redir_vld, 1);
    check("idle_pc", pc_redir, 32'h8000_0104);
    check("idle_noack_redir", pipe_flush_ack, 0);
    next_cycle();
    settle();
    check("idle_vld_n2", pc_redir_vld, 0);
    check("idle_pc_hold", pc_redir, 32'h8000_0104);
    check("idle_fa", fetch_allow, 1);

    // Odd sum and wraparound
    drive(1'b1, 32'h0000_1001, 32'h0000_0002, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("odd_pc", pc_redir, 32'h0000_1002);
    next_cycle();
    drive(1'b1, 32'hFFFF_FFFE, 32'h0000_0004, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("wrap_pc", pc_redir, 32'h0000_0002);
    check("wrap_vld", pc_redir_vld, 1);
    next_cycle();

    // Drain drop: two fetches outstanding at flush time
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    settle();
    check("drain_outs1", outs_cnt, 1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("drain_outs2", outs_cnt, 2);
    check("drain_fa_full", fetch_allow, 0);
    drive(1'b1, 32'h0000_2000, 32'h0000_0010, 1'b0, 1'b0);
    settle();
    check("drain_ack", pipe_flush_ack, 1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    check("drain_rsp1_drop", ifu_rsp_drop, 1);
    next_cycle();
    settle();
    check("drain_outs_after1", outs_cnt, 1);
    check("drain_rsp2_drop", ifu_rsp_drop, 1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    settle();
    check("drain_outs_zero", outs_cnt, 0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    check("drain_rsp3_keep", ifu_rsp_drop, 0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("drain_outs_end", outs_cnt, 0);

    // Same-cycle ack, request and response with one fetch in flight
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0000_3000, 32'h0000_0000, 1'b1, 1'b1);
    settle();
    check("same_outs_pre", outs_cnt, 1);
    check("same_ack", pipe_flush_ack, 1);
    check("same_rsp_drop", ifu_rsp_drop, 1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    check("same_outs_redir", outs_cnt, 1);
    check("same_next_drop", ifu_rsp_drop, 1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    check("same_follow_keep", ifu_rsp_drop, 0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("same_outs_end", outs_cnt, 0);

    // Flush request held through REDIR
    drive(1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
    settle();
    check("hold_ack_n", pipe_flush_ack, 1);
    check("hold_fa_n", fetch_allow, 0);
    next_cycle();
    settle();
    check("hold_ack_n1", pipe_flush_ack, 0);
    check("hold_vld_n1", pc_redir_vld, 1);
    check("hold_fa_n1", fetch_allow, 0);
    next_cycle();
    settle();
    check("hold_ack_n2", pipe_flush_ack, 1);
    check("hold_vld_n2", pc_redir_vld, 0);
    check("hold_fa_n2", fetch_allow, 0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("hold_vld_n3", pc_redir_vld, 1);
    check("hold_pc", pc_redir, 32'h0000_0300);
    next_cycle();

    // Reset while in REDIR with a stale fetch pending
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    settle();
    check("rstr_ack", pipe_flush_ack, 1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    settle();
    check("rstr_vld_n1", pc_redir_vld, 1);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    check("rstr_vld_n2", pc_redir_vld, 0);
    check("rstr_outs", outs_cnt, 0);
    check("rstr_pc", pc_redir, 0);
    check("rstr_fa", fetch_allow, 1);
    check("rstr_drop_clear", ifu_rsp_drop, 0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("underflow_outs", outs_cnt, 0);

    // Saturation on protocol-violating requests
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("sat_outs", outs_cnt, 2);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    check("sat_both_hold", outs_cnt, 2);
    next_cycle();
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("sat_drain", outs_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
